// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   XLEN   : operand width
//   ITER   : number of RUN iteration cycles
//   OP_*   : MDctl opcode encodings (6 and 7 are no-ops)
//   state_e: controller states
//   op_ctx_t: operation context captured when a Start is accepted
// Optional feature macro: MULDIV_DIV_EN (divide support).
package muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = $clog2(ITER);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic            is_div;
    logic            neg_a;
    logic            neg_b;
    logic [XLEN-1:0] b_mag;
  } op_ctx_t;

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign handling for the multiply/divide unit.
//   a_i, b_i, signed_i   : raw operands and signedness (latch stage)
//   mag_a_o, mag_b_o     : operand magnitudes
//   neg_a_o, neg_b_o     : operand is negative (signed ops only)
//   hi_i, lo_i           : unsigned result halves (FIX stage)
//   wide_i               : 1 = negate {hi,lo} as one 64-bit value, 0 = negate halves independently
//   neg_hi_i, neg_lo_i   : negate request per half
//   hi_o, lo_o           : sign-corrected result
module muldiv_signfix
  import muldiv_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            signed_i,
  output logic [XLEN-1:0] mag_a_o,
  output logic [XLEN-1:0] mag_b_o,
  output logic            neg_a_o,
  output logic            neg_b_o,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic            wide_i,
  input  logic            neg_hi_i,
  input  logic            neg_lo_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic hi_carry;

  assign neg_a_o = signed_i & a_i[XLEN-1];
  assign neg_b_o = signed_i & b_i[XLEN-1];
  assign mag_a_o = neg_a_o ? -a_i : a_i;
  assign mag_b_o = neg_b_o ? -b_i : b_i;

  // 64-bit two's complement: high half takes the carry out of negating the low half.
  assign hi_carry = wide_i ? (lo_i == '0) : 1'b1;
  assign lo_o     = neg_lo_i ? -lo_i : lo_i;
  assign hi_o     = neg_hi_i ? (~hi_i + XLEN'(hi_carry)) : hi_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
//   clock, reset_n       : clock (rising edge), async active-low reset
//   Start, MDctl, A, B   : request pulse, opcode, rs/rt operands
//   Flush                : abort a running operation (beats Start)
//   HI, LO               : result registers
//   Busy                 : high in RUN and FIX
//   Done                 : one-cycle completion pulse (DONE state)
//   DivZero              : sticky divide-by-zero flag of the last divide
// Optional feature macro: MULDIV_DIV_EN enables div/divu; without it they are no-ops.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  input  logic            Start,
  input  logic [2:0]      MDctl,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            Flush,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO,
  output logic            Busy,
  output logic            Done,
  output logic            DivZero
);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_ctx_t         ctx_q, ctx_d;
  logic [XLEN-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic            dz_q, dz_d, busy_q, busy_d, done_q, done_d;

  logic            start_mul, start_div, op_signed;
  logic [XLEN-1:0] mag_a, mag_b, fix_hi, fix_lo, step_hi, step_lo;
  logic            neg_a, neg_b;
  logic [XLEN:0]   mul_sum;

  assign start_mul = (MDctl == OP_MULT) || (MDctl == OP_MULTU);
`ifdef MULDIV_DIV_EN
  assign start_div = (MDctl == OP_DIV) || (MDctl == OP_DIVU);
`else
  assign start_div = 1'b0;
`endif
  assign op_signed = (MDctl == OP_MULT) || (MDctl == OP_DIV);

  // Quotient sign is the XOR of operand signs; remainder follows the dividend.
  muldiv_signfix u_signfix (
    .a_i      (A),
    .b_i      (B),
    .signed_i (op_signed),
    .mag_a_o  (mag_a),
    .mag_b_o  (mag_b),
    .neg_a_o  (neg_a),
    .neg_b_o  (neg_b),
    .hi_i     (acc_hi_q),
    .lo_i     (acc_lo_q),
    .wide_i   (~ctx_q.is_div),
    .neg_hi_i (ctx_q.is_div ? ctx_q.neg_a : (ctx_q.neg_a ^ ctx_q.neg_b)),
    .neg_lo_i (ctx_q.neg_a ^ ctx_q.neg_b),
    .hi_o     (fix_hi),
    .lo_o     (fix_lo)
  );

  // One iteration: shift-add multiply (acc_lo holds multiplier) or restoring divide (acc_lo holds dividend/quotient).
`ifdef MULDIV_DIV_EN
  logic [XLEN:0] div_shift;
  logic          div_ge;
`endif
  always_comb begin : step_p
    mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, ctx_q.b_mag} : '0);
    step_hi = mul_sum[XLEN:1];
    step_lo = {mul_sum[0], acc_lo_q[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
    div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, ctx_q.b_mag};
    if (ctx_q.is_div) begin
      // When div_ge holds the difference is below the divisor, so XLEN bits suffice.
      step_hi = div_ge ? (div_shift[XLEN-1:0] - ctx_q.b_mag) : div_shift[XLEN-1:0];
      step_lo = {acc_lo_q[XLEN-2:0], div_ge};
    end
`endif
  end

  // Controller next-state and datapath updates.
  always_comb begin : next_p
    state_d  = state_q;
    cnt_d    = cnt_q;
    ctx_d    = ctx_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (!Flush && Start) begin
          if (start_mul || start_div) begin
            state_d      = ST_RUN;
            cnt_d        = '0;
            ctx_d.is_div = start_div;
            ctx_d.neg_a  = neg_a;
            ctx_d.neg_b  = neg_b;
            ctx_d.b_mag  = mag_b;
            acc_hi_d     = '0;
            acc_lo_d     = mag_a;
          end else if (MDctl == OP_MTHI) begin
            hi_d = A;
          end else if (MDctl == OP_MTLO) begin
            lo_d = A;
          end
        end
      end
      ST_RUN: begin
        if (Flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITER - 1)) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (Flush) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
          hi_d    = fix_hi;
          lo_d    = fix_lo;
`ifdef MULDIV_DIV_EN
          // Zero divisor: remainder already equals the dividend; force an all-ones quotient.
          if (ctx_q.is_div) begin
            dz_d = (ctx_q.b_mag == '0);
            if (ctx_q.b_mag == '0) lo_d = '1;
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN) || (state_d == ST_FIX);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin : reg_p
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ctx_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ctx_q    <= ctx_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign HI      = hi_q;
  assign LO      = lo_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign DivZero = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random operations
// checked against an arithmetic reference model.
module tb_muldiv_unit;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clock, reset_n, Start, Flush;
  logic [2:0]  MDctl;
  logic [31:0] A, B;
  logic [31:0] HI, LO;
  logic        Busy, Done, DivZero;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [31:0] exp_hi, exp_lo;
  logic        exp_dz;

  muldiv_unit dut (
    .clock   (clock),
    .reset_n (reset_n),
    .Start   (Start),
    .MDctl   (MDctl),
    .A       (A),
    .B       (B),
    .Flush   (Flush),
    .HI      (HI),
    .LO      (LO),
    .Busy    (Busy),
    .Done    (Done),
    .DivZero (DivZero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_hi"}, HI, exp_hi);
    check({tag, "_lo"}, LO, exp_lo);
    check({tag, "_dz"}, 32'(DivZero), 32'(exp_dz));
  endtask

  function automatic bit is_long(input logic [2:0] op);
    return (op == 3'd0) || (op == 3'd1) || (DIV_EN && ((op == 3'd2) || (op == 3'd3)));
  endfunction

  // Reference model: architectural effect of one accepted operation.
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (op)
      3'd0: begin sp = sa * sb; exp_hi = sp[63:32]; exp_lo = sp[31:0]; end
      3'd1: begin up = ua * ub; exp_hi = up[63:32]; exp_lo = up[31:0]; end
      3'd2, 3'd3: begin
        if (DIV_EN) begin
          if (b == 32'd0) begin
            exp_lo = 32'hFFFF_FFFF;
            exp_hi = a;
            exp_dz = 1'b1;
          end else begin
            if (op == 3'd2) begin sq = sa / sb; sr = sa % sb; end
            else begin sq = longint'(ua / ub); sr = longint'(ua % ub); end
            exp_lo = sq[31:0];
            exp_hi = sr[31:0];
            exp_dz = 1'b0;
          end
        end
      end
      3'd4: exp_hi = a;
      3'd5: exp_lo = a;
      default: ;
    endcase
  endtask

  // Issue one op in cycle 0 and check it through completion.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; MDctl = op; A = a; B = b;
    tick();
    Start = 1'b0; MDctl = 3'($urandom_range(7)); A = $urandom; B = $urandom;
    if (is_long(op)) begin
      for (int c = 1; c <= 33; c++) begin
        check($sformatf("busy_c%0d", c), 32'(Busy), 32'd1);
        check($sformatf("done_c%0d", c), 32'(Done), 32'd0);
        check($sformatf("hold_c%0d", c), HI, exp_hi);
        tick();
      end
      model_op(op, a, b);
      check("done_c34", 32'(Done), 32'd1);
      check("busy_c34", 32'(Busy), 32'd0);
      check_regs("res");
    end else begin
      model_op(op, a, b);
      check("short_busy", 32'(Busy), 32'd0);
      check("short_done", 32'(Done), 32'd0);
      check_regs("short");
    end
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] ra, rb;
    reset_n = 1'b0; Start = 1'b0; Flush = 1'b0; MDctl = 3'd0; A = '0; B = '0;
    exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
    #2;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check_regs("rst");
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Unsigned max product, Done only in cycle 34.
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_hi", HI, 32'hFFFF_FFFE);
    check("multu_max_lo", LO, 32'h0000_0001);
    tick();
    check("done_c35", 32'(Done), 32'd0);

    run_op(3'd0, 32'hFFFF_FFFD, 32'd7);
    check("mult_neg_hi", HI, 32'hFFFF_FFFF);
    check("mult_neg_lo", LO, 32'hFFFF_FFEB);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);

    // Flush beats Start while in DONE.
    Start = 1'b1; MDctl = 3'd0; A = 32'd9; B = 32'd9; Flush = 1'b1;
    tick();
    Start = 1'b0; Flush = 1'b0;
    check("fl_start_busy", 32'(Busy), 32'd0);
    tick();
    check("fl_start_busy2", 32'(Busy), 32'd0);
    check("fl_start_done", 32'(Done), 32'd0);
    check_regs("fl_start");

    run_op(3'd3, 32'd100, 32'd0);
    run_op(3'd1, 32'd2, 32'd3);
    check("multu_small_lo", LO, 32'd6);

    // Start ignored while busy, then Flush in RUN.
    Start = 1'b1; MDctl = 3'd1; A = 32'd5; B = 32'd5;
    tick();
    Start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      check($sformatf("fr_busy_c%0d", c), 32'(Busy), 32'(c <= 10));
      check($sformatf("fr_done_c%0d", c), 32'(Done), 32'd0);
      check_regs("fr");
      Start = (c == 5); MDctl = 3'd5; A = 32'h1234;
      Flush = (c == 10);
      tick();
    end
    Start = 1'b0; Flush = 1'b0;

    // Flush in FIX.
    Start = 1'b1; MDctl = 3'd0; A = 32'h0001_0000; B = 32'h0001_0000;
    tick();
    Start = 1'b0;
    for (int c = 1; c < 33; c++) tick();
    check("ff_busy_c33", 32'(Busy), 32'd1);
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    check("ff_busy_c34", 32'(Busy), 32'd0);
    check("ff_done_c34", 32'(Done), 32'd0);
    check_regs("ff");
    tick();
    check("ff_done_c35", 32'(Done), 32'd0);

    // Flush beats mthi in IDLE.
    Start = 1'b1; MDctl = 3'd4; A = 32'hDEAD_BEEF; Flush = 1'b1;
    tick();
    Start = 1'b0; Flush = 1'b0;
    check_regs("fl_mthi");

    run_op(3'd6, 32'h1111_1111, 32'h2222_2222);
    run_op(3'd7, 32'h3333_3333, 32'h4444_4444);
    run_op(3'd4, 32'hCAFE_0001, 32'd0);
    run_op(3'd5, 32'hCAFE_0002, 32'd0);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(16));
        2: ra = 32'h8000_0000;
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(op, ra, rb);
    end

    // Asynchronous reset in the middle of a multiply.
    run_op(3'd1, 32'h0BAD_F00D, 32'h0000_1234);
    Start = 1'b1; MDctl = 3'd0; A = 32'h7654_3210; B = 32'h0000_0042;
    tick();
    Start = 1'b0;
    for (int c = 1; c < 15; c++) tick();
    reset_n = 1'b0;
    #1;
    exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
    check("mr_busy", 32'(Busy), 32'd0);
    check("mr_done", 32'(Done), 32'd0);
    check_regs("mr");
    #2;
    reset_n = 1'b1;
    tick();
    check("mr_idle_busy", 32'(Busy), 32'd0);
    run_op(3'd4, 32'h0000_ABCD, 32'd0);
    check("mr_mthi", HI, 32'h0000_ABCD);
    run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0003);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
